// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : writeback_buffer
// Description : Writeback buffer between a cache and the next memory level.
//               Dirty-line evictions are absorbed into a small FIFO and drained
//               downstream in the background. Line reads are forwarded from a
//               buffered entry on an address match, otherwise fetched from the
//               next level through a single-outstanding read FSM.
//               Optional build macro WB_COALESCE_EN: a write that hits a
//               buffered line overwrites that entry in place.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_buffer #(
    parameter int B         = 64,
    parameter int ADDR_BITS = 64,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 up_valid_in,
    output logic                 up_ready_out,
    input  logic [ADDR_BITS-1:0] up_addr_in,
    input  logic [B*8-1:0]       up_value_in,
    input  logic                 up_we_in,
    output logic                 up_valid_out,
    input  logic                 up_ready_in,
    output logic [ADDR_BITS-1:0] up_addr_out,
    output logic [B*8-1:0]       up_value_out,
    output logic                 dn_valid_out,
    input  logic                 dn_ready_in,
    output logic [ADDR_BITS-1:0] dn_addr_out,
    output logic [B*8-1:0]       dn_value_out,
    output logic                 dn_we_out,
    input  logic                 dn_valid_in,
    output logic                 dn_ready_out,
    input  logic [ADDR_BITS-1:0] dn_addr_in,
    input  logic [B*8-1:0]       dn_value_in
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(B - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] R_RESP  = 2'd3;

    logic [1:0]           rstate_q, rstate_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic                 wr_pending_q, wr_pending_d;
    logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [ADDR_BITS-1:0] resp_addr_q, resp_addr_d;
    logic [B*8-1:0]       resp_data_q, resp_data_d;

    logic [ADDR_BITS-1:0] entry_addr_q [DEPTH];
    logic [B*8-1:0]       entry_data_q [DEPTH];

    logic [ADDR_BITS-1:0] up_aligned;
    logic                 hit;
    logic [PW-1:0]        hit_idx;
    logic [PW-1:0]        scan_idx;
    logic                 co_match;
    logic                 issue_rd;
    logic                 drain;
    logic                 pop;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 coalesce;
    logic                 alloc;
    logic                 entry_we;
    logic [PW-1:0]        entry_idx;

    assign up_aligned = up_addr_in & LINE_MASK;

    // Youngest valid entry whose line address matches the request (scan oldest to youngest)
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] && (entry_addr_q[scan_idx] == up_aligned)) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

`ifdef WB_COALESCE_EN
    assign co_match = hit;
`else
    assign co_match = 1'b0;
`endif

    // Read FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) rstate_q <= R_IDLE;
        else        rstate_q <= rstate_d;
    end

    // Read FSM next-state logic
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (rd_acc) rstate_d = hit ? R_RESP : R_ISSUE;
            R_ISSUE: if (issue_rd && dn_ready_in) rstate_d = R_WAIT;
            R_WAIT:  if (dn_valid_in) rstate_d = R_RESP;
            R_RESP:  if (up_ready_in) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // FSM outputs and downstream port arbitration; a stalled drain keeps the port
    always_comb begin
        issue_rd     = (rstate_q == R_ISSUE) && !wr_pending_q;
        drain        = !issue_rd && (count_q != '0);
        dn_valid_out = issue_rd || drain;
        dn_we_out    = drain;
        dn_addr_out  = '0;
        dn_value_out = '0;
        if (issue_rd) begin
            dn_addr_out = req_addr_q;
        end else if (drain) begin
            dn_addr_out  = entry_addr_q[head_q];
            dn_value_out = entry_data_q[head_q];
        end
        dn_ready_out = (rstate_q == R_WAIT);
        up_valid_out = (rstate_q == R_RESP);
        up_addr_out  = (rstate_q == R_RESP) ? resp_addr_q : '0;
        up_value_out = (rstate_q == R_RESP) ? resp_data_q : '0;
        up_ready_out = !rst_in && (rstate_q == R_IDLE) &&
                       (up_we_in ? ((count_q < CW'(DEPTH)) || co_match) : 1'b1);
    end

    // FIFO bookkeeping: pop on downstream write transfer, allocate or coalesce on write accept
    always_comb begin
        pop       = drain && dn_ready_in;
        wr_acc    = up_valid_in && up_ready_out && up_we_in;
        rd_acc    = up_valid_in && up_ready_out && !up_we_in;
        // a matching head leaving this cycle cannot absorb the write
        coalesce  = co_match && !((hit_idx == head_q) && pop);
        alloc     = wr_acc && !coalesce;
        entry_we  = wr_acc;
        entry_idx = coalesce ? hit_idx : tail_q;

        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (alloc && !pop)      count_d = count_q + CW'(1);
        else if (pop && !alloc) count_d = count_q - CW'(1);

        wr_pending_d = drain && !dn_ready_in;
    end

    // FIFO control registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            wr_pending_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            wr_pending_q <= wr_pending_d;
        end
    end

    // Entry storage; contents are qualified by valid_q so no reset is needed
    always_ff @(posedge clk_in) begin
        if (entry_we) begin
            entry_addr_q[entry_idx] <= up_aligned;
            entry_data_q[entry_idx] <= up_value_in;
        end
    end

    // Read request and response capture; hits use pre-pop entry data
    always_comb begin
        req_addr_d  = req_addr_q;
        resp_addr_d = resp_addr_q;
        resp_data_d = resp_data_q;
        if (rd_acc) begin
            req_addr_d = up_aligned;
            if (hit) begin
                resp_addr_d = up_aligned;
                resp_data_d = entry_data_q[hit_idx];
            end
        end
        if ((rstate_q == R_WAIT) && dn_valid_in) begin
            resp_addr_d = dn_addr_in;
            resp_data_d = dn_value_in;
        end
    end

    // Read request and response registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            req_addr_q  <= '0;
            resp_addr_q <= '0;
            resp_data_q <= '0;
        end else begin
            req_addr_q  <= req_addr_d;
            resp_addr_q <= resp_addr_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule
`default_nettype wire
